// File: rtl/opb_register_bank_ppc2user.sv
// OPB slave bank of C_NUM_REGS software-writable 32-bit control registers exposed to user logic,
// with byte-enable writes, readback, per-register update strobes and optional self-clearing pulse mode.
module opb_register_bank_ppc2user #(
  parameter logic [31:0] C_BASEADDR   = 32'h010B2200,
  parameter logic [31:0] C_HIGHADDR   = 32'h010B22FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 4,
  parameter logic [63:0] C_PULSE_MASK = 64'h0,
  parameter int          C_PULSE_LEN  = 1,
  parameter              C_FAMILY     = "virtex5"
) (
  input  logic                          OPB_Clk,
  input  logic                          OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]       OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]     OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]       OPB_DBus,
  input  logic                          OPB_RNW,
  input  logic                          OPB_select,
  input  logic                          OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]       Sl_DBus,
  output logic                          Sl_errAck,
  output logic                          Sl_retry,
  output logic                          Sl_toutSup,
  output logic                          Sl_xferAck,
  output logic [32*C_NUM_REGS-1:0]      user_data_out,
  output logic [C_NUM_REGS-1:0]         user_strobe
);

  // OPB numbers bits MSB-first; positional assignment maps bit 0 onto bit 31.
  logic [31:0]           addr;
  logic [31:0]           wdata;
  logic [3:0]            be;
  logic [31:0]           offset;
  logic [31:0]           idx;
  logic [31:0]           read_val;
  logic [31:0]           rdata_q;
  logic                  ack_q;
  logic                  in_range;
  logic                  hit;
  logic [C_NUM_REGS-1:0] wr_en;
  logic [31:0]           regs [C_NUM_REGS];
  logic [7:0]            cnt  [C_NUM_REGS];
  logic                  unused_inputs;

  assign addr          = OPB_ABus;
  assign wdata         = OPB_DBus;
  assign be            = OPB_BE;
  assign in_range      = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign hit           = OPB_select && in_range && !ack_q;
  assign offset        = addr - C_BASEADDR;
  assign idx           = {2'b00, offset[31:2]};
  assign unused_inputs = OPB_seqAddr ^ (^offset[1:0]);

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur, input logic [31:0] data,
                                              input logic [3:0] en);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = en[b] ? data[8*b +: 8] : cur[8*b +: 8];
    end
    return merged;
  endfunction

  // Indices beyond C_NUM_REGS match no register: reads give 0 and writes are dropped.
  always_comb begin
    read_val = '0;
    wr_en    = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (idx == 32'(i)) begin
        read_val = regs[i];
        wr_en[i] = hit && !OPB_RNW;
      end
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      ack_q       <= 1'b0;
      rdata_q     <= '0;
      user_strobe <= '0;
      for (int i = 0; i < C_NUM_REGS; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      ack_q       <= hit;
      rdata_q     <= (hit && OPB_RNW) ? read_val : 32'h0;
      user_strobe <= wr_en;
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (wr_en[i]) begin
          regs[i] <= merge_bytes(regs[i], wdata, be);
          if (C_PULSE_MASK[i]) cnt[i] <= 8'(C_PULSE_LEN);
        end else if (C_PULSE_MASK[i] && cnt[i] != 8'd0) begin
          // Last hold cycle: drop the pulse register back to idle.
          cnt[i] <= cnt[i] - 8'd1;
          if (cnt[i] == 8'd1) regs[i] <= '0;
        end
      end
    end
  end

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = regs[g];
  end

  assign Sl_DBus    = rdata_q;
  assign Sl_xferAck = ack_q;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2user.sv
// Self-checking bench for opb_register_bank_ppc2user: randomized OPB transfers against a
// cycle-stamped register model, plus directed pulse, back-to-back, range and reset scenarios.
module tb_opb_register_bank_ppc2user;

  localparam logic [31:0] BASE  = 32'h010B2200;
  localparam logic [31:0] HIGH  = 32'h010B22FF;
  localparam int          NREGS = 4;
  localparam logic [63:0] PMASK = 64'h1;
  localparam int          PLEN  = 3;

  logic                 OPB_Clk = 1'b0;
  logic                 OPB_Rst;
  logic [0:31]          OPB_ABus;
  logic [0:3]           OPB_BE;
  logic [0:31]          OPB_DBus;
  logic                 OPB_RNW;
  logic                 OPB_select;
  logic                 OPB_seqAddr;
  logic [0:31]          Sl_DBus;
  logic                 Sl_errAck;
  logic                 Sl_retry;
  logic                 Sl_toutSup;
  logic                 Sl_xferAck;
  logic [32*NREGS-1:0]  user_data_out;
  logic [NREGS-1:0]     user_strobe;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Model: last written value per register plus, for pulse registers, the cycle it clears.
  logic [31:0] mval [NREGS];
  int          mexp [NREGS];

  opb_register_bank_ppc2user #(
    .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
    .C_NUM_REGS(NREGS), .C_PULSE_MASK(PMASK), .C_PULSE_LEN(PLEN), .C_FAMILY("virtex5")
  ) dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus), .OPB_BE(OPB_BE),
    .OPB_DBus(OPB_DBus), .OPB_RNW(OPB_RNW), .OPB_select(OPB_select), .OPB_seqAddr(OPB_seqAddr),
    .Sl_DBus(Sl_DBus), .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup),
    .Sl_xferAck(Sl_xferAck), .user_data_out(user_data_out), .user_strobe(user_strobe)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  task automatic tick();
    @(posedge OPB_Clk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) begin
      mval[i] = 32'h0;
      mexp[i] = 0;
    end
  endtask

  function automatic logic [31:0] model_value(input int i, input int t);
    if (PMASK[i] && t >= mexp[i]) return 32'h0;
    return mval[i];
  endfunction

  function automatic logic [32*NREGS-1:0] model_udo(input int t);
    logic [32*NREGS-1:0] v;
    for (int i = 0; i < NREGS; i++) v[32*i +: 32] = model_value(i, t);
    return v;
  endfunction

  function automatic bit addr_in_range(input logic [31:0] a);
    return (a >= BASE) && (a <= HIGH);
  endfunction

  function automatic int reg_of(input logic [31:0] a);
    if (!addr_in_range(a)) return -1;
    if (((a - BASE) / 4) >= NREGS) return -1;
    return int'((a - BASE) / 4);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a, input int k);
    int r = reg_of(a);
    if (r < 0) return 32'h0;
    return model_value(r, k);
  endfunction

  function automatic logic [3:0] model_strobe(input logic [31:0] a, input logic rnw);
    int r = reg_of(a);
    if (rnw || r < 0) return 4'h0;
    return 4'(1 << r);
  endfunction

  // BE[0] enables the most significant byte.
  task automatic model_write(input logic [31:0] a, input logic [0:3] bes, input logic [31:0] d,
                             input int k);
    int r = reg_of(a);
    logic [31:0] v;
    if (r >= 0) begin
      v = model_value(r, k);
      for (int b = 0; b < 4; b++)
        if (bes[b]) v[31-8*b -: 8] = d[31-8*b -: 8];
      mval[r] = v;
      mexp[r] = k + 1 + PLEN;
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [0:3] bes, input logic [31:0] d,
                       input logic rnw, input logic sel);
    OPB_ABus   = a;
    OPB_BE     = bes;
    OPB_DBus   = d;
    OPB_RNW    = rnw;
    OPB_select = sel;
  endtask

  // One single-cycle select; returns what was seen in the two following cycles.
  task automatic bus_cycle(input logic [31:0] a, input logic [0:3] bes, input logic [31:0] d,
                           input logic rnw, output logic ack1, output logic [31:0] rd1,
                           output logic [3:0] stb1, output logic [32*NREGS-1:0] udo1,
                           output logic ack2, output logic [31:0] rd2, output logic [3:0] stb2);
    drive(a, bes, d, rnw, 1'b1);
    tick();
    ack1 = Sl_xferAck; rd1 = Sl_DBus; stb1 = user_strobe; udo1 = user_data_out;
    OPB_select = 1'b0;
    tick();
    ack2 = Sl_xferAck; rd2 = Sl_DBus; stb2 = user_strobe;
  endtask

  task automatic test_reset();
    logic ack1, ack2;
    logic [31:0] rd1, rd2;
    logic [3:0] stb1, stb2;
    logic [32*NREGS-1:0] udo1;
    OPB_Rst = 1'b1;
    drive(BASE, 4'b1111, 32'h0, 1'b1, 1'b0);
    tick();
    tick();
    model_reset();
    checks++; if (Sl_xferAck !== 1'b0) begin failures++; $display("[TB] FAIL reset_ack: got %b expected 0", Sl_xferAck); end
    checks++; if (Sl_DBus !== 32'h0) begin failures++; $display("[TB] FAIL reset_dbus: got %h expected 0", Sl_DBus); end
    checks++; if (user_data_out !== '0) begin failures++; $display("[TB] FAIL reset_udo: got %h expected 0", user_data_out); end
    checks++; if (user_strobe !== 4'h0) begin failures++; $display("[TB] FAIL reset_strobe: got %b expected 0", user_strobe); end
    checks++; if ({Sl_errAck, Sl_retry, Sl_toutSup} !== 3'b000) begin failures++; $display("[TB] FAIL tied_outputs: got %b expected 000", {Sl_errAck, Sl_retry, Sl_toutSup}); end
    OPB_Rst = 1'b0;
    bus_cycle(BASE, 4'b1111, 32'h0, 1'b1, ack1, rd1, stb1, udo1, ack2, rd2, stb2);
    checks++; if (ack1 !== 1'b1) begin failures++; $display("[TB] FAIL reset_read_ack: got %b expected 1", ack1); end
    checks++; if (rd1 !== 32'h0) begin failures++; $display("[TB] FAIL reset_read_data: got %h expected 0", rd1); end
    checks++; if (ack2 !== 1'b0) begin failures++; $display("[TB] FAIL reset_read_single_ack: got %b expected 0", ack2); end
  endtask

  task automatic test_write_readback();
    logic ack1, ack2;
    logic [31:0] rd1, rd2;
    logic [3:0] stb1, stb2;
    logic [32*NREGS-1:0] udo1;
    int k;
    k = cyc;
    bus_cycle(BASE + 32'h4, 4'b1111, 32'hDEADBEEF, 1'b0, ack1, rd1, stb1, udo1, ack2, rd2, stb2);
    model_write(BASE + 32'h4, 4'b1111, 32'hDEADBEEF, k);
    checks++; if (ack1 !== 1'b1) begin failures++; $display("[TB] FAIL wr_ack: got %b expected 1", ack1); end
    checks++; if (udo1[63:32] !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL wr_reg1: got %h expected deadbeef", udo1[63:32]); end
    checks++; if (stb1 !== 4'b0010) begin failures++; $display("[TB] FAIL wr_strobe: got %b expected 0010", stb1); end
    checks++; if (stb2 !== 4'b0000) begin failures++; $display("[TB] FAIL wr_strobe_once: got %b expected 0000", stb2); end
    checks++; if (rd1 !== 32'h0) begin failures++; $display("[TB] FAIL wr_dbus_zero: got %h expected 0", rd1); end
    bus_cycle(BASE + 32'h4, 4'b0000, 32'h0, 1'b1, ack1, rd1, stb1, udo1, ack2, rd2, stb2);
    checks++; if (rd1 !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL readback: got %h expected deadbeef", rd1); end
    checks++; if (rd2 !== 32'h0) begin failures++; $display("[TB] FAIL readback_dbus_idle: got %h expected 0", rd2); end
    k = cyc;
    bus_cycle(BASE + 32'h4, 4'b0101, 32'h11223344, 1'b0, ack1, rd1, stb1, udo1, ack2, rd2, stb2);
    model_write(BASE + 32'h4, 4'b0101, 32'h11223344, k);
    checks++; if (udo1[63:32] !== 32'hDE22BE44) begin failures++; $display("[TB] FAIL byte_enable: got %h expected de22be44", udo1[63:32]); end
  endtask

  task automatic test_random();
    logic ack1, ack2;
    logic [31:0] rd1, rd2, a, d, exp_rd;
    logic [3:0] stb1, stb2, exp_stb;
    logic [0:3] bes;
    logic rnw;
    logic [32*NREGS-1:0] udo1;
    int k;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = BASE + 32'(4 * $urandom_range(0, NREGS - 1)) + 32'($urandom_range(0, 3));
        2:       a = BASE + 32'h10 + 32'($urandom_range(0, 32'hEF));
        default: a = $urandom_range(0, 1) ? HIGH + 32'h1 + 32'($urandom_range(0, 255))
                                          : BASE - 32'h1 - 32'($urandom_range(0, 255));
      endcase
      d   = $urandom;
      bes = 4'($urandom);
      rnw = 1'($urandom_range(0, 1));
      k   = cyc;
      exp_rd  = (rnw && addr_in_range(a)) ? model_read(a, k) : 32'h0;
      exp_stb = model_strobe(a, rnw);
      bus_cycle(a, bes, d, rnw, ack1, rd1, stb1, udo1, ack2, rd2, stb2);
      if (!rnw && addr_in_range(a)) model_write(a, bes, d, k);
      checks++; if (ack1 !== addr_in_range(a)) begin failures++; $display("[TB] FAIL rand_ack addr=%h: got %b expected %b", a, ack1, addr_in_range(a)); end
      checks++; if (rd1 !== exp_rd) begin failures++; $display("[TB] FAIL rand_rdata addr=%h: got %h expected %h", a, rd1, exp_rd); end
      checks++; if (stb1 !== exp_stb) begin failures++; $display("[TB] FAIL rand_strobe addr=%h: got %b expected %b", a, stb1, exp_stb); end
      checks++; if (udo1 !== model_udo(k + 1)) begin failures++; $display("[TB] FAIL rand_udo addr=%h: got %h expected %h", a, udo1, model_udo(k + 1)); end
      checks++; if ({ack2, rd2, stb2} !== 37'h0) begin failures++; $display("[TB] FAIL rand_idle: got ack=%b data=%h strobe=%b expected all 0", ack2, rd2, stb2); end
    end
  endtask

  task automatic test_pulse();
    int k;
    for (int i = 0; i < PLEN + 1; i++) tick();
    k = cyc;
    drive(BASE, 4'b1111, 32'h00000001, 1'b0, 1'b1);
    model_write(BASE, 4'b1111, 32'h00000001, k);
    tick();
    checks++; if (user_data_out[31:0] !== 32'h1) begin failures++; $display("[TB] FAIL pulse_start: got %h expected 1", user_data_out[31:0]); end
    checks++; if (user_strobe !== 4'b0001) begin failures++; $display("[TB] FAIL pulse_strobe1: got %b expected 0001", user_strobe); end
    OPB_select = 1'b0;
    tick();
    drive(BASE, 4'b1000, 32'hAB000000, 1'b0, 1'b1);
    model_write(BASE, 4'b1000, 32'hAB000000, cyc);
    tick();
    checks++; if (user_strobe !== 4'b0001) begin failures++; $display("[TB] FAIL pulse_strobe2: got %b expected 0001", user_strobe); end
    OPB_select = 1'b0;
    while (cyc <= k + 7) begin
      checks++; if (user_data_out[31:0] !== model_value(0, cyc)) begin failures++; $display("[TB] FAIL pulse_hold cycle=k+%0d: got %h expected %h", cyc - k, user_data_out[31:0], model_value(0, cyc)); end
      tick();
    end
    checks++; if (user_data_out[31:0] !== 32'h0) begin failures++; $display("[TB] FAIL pulse_cleared: got %h expected 0", user_data_out[31:0]); end
  endtask

  task automatic test_back_to_back();
    logic exp_ack [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    drive(BASE + 32'h4, 4'b1111, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) OPB_select = 1'b0;
      checks++; if (Sl_xferAck !== exp_ack[i]) begin failures++; $display("[TB] FAIL b2b_ack cycle=k+%0d: got %b expected %b", i + 1, Sl_xferAck, exp_ack[i]); end
      checks++; if (Sl_DBus !== (exp_ack[i] ? model_value(1, cyc) : 32'h0)) begin failures++; $display("[TB] FAIL b2b_data cycle=k+%0d: got %h", i + 1, Sl_DBus); end
    end
  endtask

  task automatic test_out_of_range();
    logic ack1, ack2;
    logic [31:0] rd1, rd2;
    logic [3:0] stb1, stb2;
    logic [32*NREGS-1:0] udo1;
    int k;
    bus_cycle(BASE + 32'h80, 4'b1111, 32'h0, 1'b1, ack1, rd1, stb1, udo1, ack2, rd2, stb2);
    checks++; if (ack1 !== 1'b1) begin failures++; $display("[TB] FAIL hole_read_ack: got %b expected 1", ack1); end
    checks++; if (rd1 !== 32'h0) begin failures++; $display("[TB] FAIL hole_read_data: got %h expected 0", rd1); end
    k = cyc;
    bus_cycle(BASE + 32'h80, 4'b1111, 32'hFFFFFFFF, 1'b0, ack1, rd1, stb1, udo1, ack2, rd2, stb2);
    checks++; if (ack1 !== 1'b1) begin failures++; $display("[TB] FAIL hole_write_ack: got %b expected 1", ack1); end
    checks++; if (stb1 !== 4'h0) begin failures++; $display("[TB] FAIL hole_write_strobe: got %b expected 0", stb1); end
    checks++; if (udo1 !== model_udo(k + 1)) begin failures++; $display("[TB] FAIL hole_write_udo: got %h expected %h", udo1, model_udo(k + 1)); end
    drive(32'h010B2300, 4'b1111, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (Sl_xferAck !== 1'b0 || Sl_DBus !== 32'h0) begin failures++; $display("[TB] FAIL outside_no_ack: got ack=%b data=%h expected 0/0", Sl_xferAck, Sl_DBus); end
    end
    OPB_select = 1'b0;
    tick();
  endtask

  task automatic test_reset_in_flight();
    drive(BASE + 32'h8, 4'b1111, 32'h12345678, 1'b0, 1'b1);
    tick();
    OPB_select = 1'b0;
    OPB_Rst    = 1'b1;
    tick();
    model_reset();
    checks++; if (user_data_out !== '0) begin failures++; $display("[TB] FAIL rst_flight_udo: got %h expected 0", user_data_out); end
    checks++; if ({Sl_xferAck, user_strobe} !== 5'b0) begin failures++; $display("[TB] FAIL rst_flight_ack_strobe: got ack=%b strobe=%b expected 0", Sl_xferAck, user_strobe); end
    drive(BASE + 32'hC, 4'b1111, 32'hCAFEF00D, 1'b0, 1'b1);
    tick();
    checks++; if ({Sl_xferAck, user_strobe} !== 5'b0) begin failures++; $display("[TB] FAIL rst_hit_ignored: got ack=%b strobe=%b expected 0", Sl_xferAck, user_strobe); end
    checks++; if (user_data_out !== '0) begin failures++; $display("[TB] FAIL rst_hit_udo: got %h expected 0", user_data_out); end
    OPB_select = 1'b0;
    OPB_Rst    = 1'b0;
    tick();
    checks++; if ({Sl_xferAck, user_strobe, Sl_DBus} !== 37'b0) begin failures++; $display("[TB] FAIL rst_no_stale: got ack=%b strobe=%b data=%h expected 0", Sl_xferAck, user_strobe, Sl_DBus); end
  endtask

  initial begin
    OPB_seqAddr = 1'b0;
    model_reset();
    test_reset();
    test_write_readback();
    test_random();
    test_pulse();
    test_back_to_back();
    test_out_of_range();
    test_reset_in_flight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
